// File: rtl/axi4_ram_slave.sv
// AXI4 responder that terminates AW/W/B and AR/R traffic into a word RAM.
// Write and read paths are independent FSMs, one transaction in flight each.
module axi4_ram_slave #(
    parameter int A = 32,
    parameter int N = 8,
    parameter int I = 1,
    parameter int D = 256
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic [I-1:0]   awid,
    input  logic [A-1:0]   awaddr,
    input  logic [7:0]     awlen,
    input  logic [2:0]     awsize,
    input  logic [1:0]     awburst,
    input  logic           awvalid,
    output logic           awready,
    input  logic [8*N-1:0] wdata,
    input  logic [N-1:0]   wstrb,
    input  logic           wlast,
    input  logic           wvalid,
    output logic           wready,
    output logic [I-1:0]   bid,
    output logic [1:0]     bresp,
    output logic           bvalid,
    input  logic           bready,
    input  logic [I-1:0]   arid,
    input  logic [A-1:0]   araddr,
    input  logic [7:0]     arlen,
    input  logic [2:0]     arsize,
    input  logic [1:0]     arburst,
    input  logic           arvalid,
    output logic           arready,
    output logic [I-1:0]   rid,
    output logic [8*N-1:0] rdata,
    output logic [1:0]     rresp,
    output logic           rlast,
    output logic           rvalid,
    input  logic           rready
);
    localparam int LN = $clog2(N);
    localparam int LD = $clog2(D);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    logic [8*N-1:0] mem [D];

    // Address of the next beat for FIXED / INCR / WRAP bursts.
    function automatic logic [A-1:0] next_addr(
        input logic [A-1:0] a,
        input logic [7:0]   len,
        input logic [1:0]   burst
    );
        logic [A-1:0] mask;
        logic [A-1:0] nxt;
        mask = ((A'(len) + A'(1)) << LN) - A'(1);
        nxt  = a + A'(N);
        unique case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | (nxt & mask);
            default: return nxt;
        endcase
    endfunction

    // Requests the RAM cannot serve as full-width beats are answered SLVERR.
    function automatic logic bad_req(
        input logic [7:0] len,
        input logic [2:0] size,
        input logic [1:0] burst
    );
        logic wrap_ok;
        wrap_ok = (len == 8'd1) || (len == 8'd3) ||
                  (len == 8'd7) || (len == 8'd15);
        return (size != 3'(LN)) || (burst == 2'b11) ||
               (burst == 2'b10 && !wrap_ok);
    endfunction

    // ---------------- write path ----------------
    w_state_e     w_state_q, w_state_d;
    logic [I-1:0] w_id_q, w_id_d;
    logic [A-1:0] w_addr_q, w_addr_d;
    logic [7:0]   w_len_q, w_len_d;
    logic [1:0]   w_burst_q, w_burst_d;
    logic         w_err_q, w_err_d;
    logic         w_lerr_q, w_lerr_d;
    logic [7:0]   w_cnt_q, w_cnt_d;
    logic [1:0]   bresp_q, bresp_d;
    logic         w_we;
    logic [LD-1:0] w_idx;

    assign w_idx   = w_addr_q[LN+LD-1:LN];
    assign awready = (w_state_q == W_IDLE);
    assign wready  = (w_state_q == W_DATA);
    assign bvalid  = (w_state_q == W_RESP);
    assign bid     = w_id_q;
    assign bresp   = bresp_q;

    // Write FSM next state: latch AW, count W beats, then hold B.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_err_d   = w_err_q;
        w_lerr_d  = w_lerr_q;
        w_cnt_d   = w_cnt_q;
        bresp_d   = bresp_q;
        w_we      = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (awvalid) begin
                    w_id_d    = awid;
                    w_addr_d  = awaddr;
                    w_len_d   = awlen;
                    w_burst_d = awburst;
                    w_err_d   = bad_req(awlen, awsize, awburst);
                    w_lerr_d  = 1'b0;
                    w_cnt_d   = 8'd0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    w_we = !w_err_q;
                    if (w_cnt_q == w_len_q) begin
                        bresp_d   = (w_err_q || w_lerr_q || !wlast)
                                    ? SLVERR : OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        w_lerr_d = w_lerr_q | wlast;
                        w_cnt_d  = w_cnt_q + 8'd1;
                        w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
                    end
                end
            end
            W_RESP: begin
                if (bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_burst_q <= '0;
            w_err_q   <= 1'b0;
            w_lerr_q  <= 1'b0;
            w_cnt_q   <= '0;
            bresp_q   <= OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_err_q   <= w_err_d;
            w_lerr_q  <= w_lerr_d;
            w_cnt_q   <= w_cnt_d;
            bresp_q   <= bresp_d;
        end
    end

    // Byte-strobed RAM write; contents survive reset.
    always_ff @(posedge aclk) begin
        if (w_we) begin
            for (int b = 0; b < N; b++) begin
                if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_e      r_state_q, r_state_d;
    logic [I-1:0]  r_id_q, r_id_d;
    logic [A-1:0]  r_addr_q, r_addr_d;
    logic [7:0]    r_len_q, r_len_d;
    logic [1:0]    r_burst_q, r_burst_d;
    logic          r_err_q, r_err_d;
    logic [7:0]    r_cnt_q, r_cnt_d;
    logic          rlast_q, rlast_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [8*N-1:0] rdata_q, rdata_d;
    logic [8*N-1:0] rd_word;
    logic          rd_load;

    assign arready = (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_DATA);
    assign rid     = r_id_q;
    assign rlast   = rlast_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;
    assign rd_word = mem[r_addr_d[LN+LD-1:LN]];

    // Read FSM next state: latch AR, then stream one beat per accepted R.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_err_d   = r_err_q;
        r_cnt_d   = r_cnt_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rd_load   = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    r_id_d    = arid;
                    r_addr_d  = araddr;
                    r_len_d   = arlen;
                    r_burst_d = arburst;
                    r_err_d   = bad_req(arlen, arsize, arburst);
                    r_cnt_d   = 8'd0;
                    rlast_d   = (arlen == 8'd0);
                    rresp_d   = r_err_d ? SLVERR : OKAY;
                    rd_load   = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d  = r_cnt_q + 8'd1;
                        r_addr_d = next_addr(r_addr_q, r_len_q, r_burst_q);
                        rlast_d  = (r_cnt_d == r_len_q);
                        rd_load  = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Next read word; errored bursts return zeros.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_load) rdata_d = r_err_d ? '0 : rd_word;
    end

    // Read FSM registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_burst_q <= '0;
            r_err_q   <= 1'b0;
            r_cnt_q   <= '0;
            rlast_q   <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_err_q   <= r_err_d;
            r_cnt_q   <= r_cnt_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule
